// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: buffering front end for sdram_ctrl.
// A write FIFO collects user words and drains them through burst write
// requests; a read FIFO is filled by burst read prefetches. Burst addresses
// auto-increment and wrap inside their region.
// Optional build macro SDRAM_FIFO_CTRL_ERR_EN adds the sticky error flags
// wr_overflow and rd_underflow.
module sdram_fifo_ctrl #(
  parameter int          FIFO_AW = 10,
  parameter logic [23:0] WR_BASE = 24'd0,
  parameter logic [23:0] WR_END  = 24'd1024,
  parameter logic [23:0] RD_BASE = 24'd0,
  parameter logic [23:0] RD_END  = 24'd1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wr_fifo_wr_en,
  input  logic [15:0]      wr_fifo_wr_data,
  input  logic             rd_fifo_rd_en,
  output logic [15:0]      rd_fifo_rd_data,
  input  logic             read_valid,
  input  logic [8:0]       wr_burst_len_in,
  input  logic [8:0]       rd_burst_len_in,
  output logic [FIFO_AW:0] wr_fifo_num,
  output logic [FIFO_AW:0] rd_fifo_num,
`ifdef SDRAM_FIFO_CTRL_ERR_EN
  output logic             wr_overflow,
  output logic             rd_underflow,
`endif
  input  logic             init_end,
  output logic             sdram_wr_req,
  input  logic             sdram_wr_ack,
  output logic [23:0]      sdram_wr_addr,
  output logic [8:0]       wr_burst_len,
  output logic [15:0]      sdram_data_in,
  output logic             sdram_rd_req,
  input  logic             sdram_rd_ack,
  output logic [23:0]      sdram_rd_addr,
  output logic [8:0]       rd_burst_len,
  input  logic [15:0]      sdram_data_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  // Compare width wide enough for both the FIFO count and a 9-bit length.
  localparam int CW = (FIFO_AW + 2 > 10) ? FIFO_AW + 2 : 10;
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      DEPTH_W  = {{(CW-FIFO_AW-1){1'b0}}, CNT_FULL};

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

  // Next burst start address; falls back to base when the following burst
  // would run past the region limit.
  function automatic logic [23:0] next_addr(input logic [23:0] addr,
                                            input logic [8:0]  len,
                                            input logic [23:0] base,
                                            input logic [23:0] lim);
    logic [23:0] nxt;
    logic [24:0] chk;
    nxt = addr + {15'd0, len};
    chk = {1'b0, nxt} + {16'd0, len};
    if (chk > {1'b0, lim}) next_addr = base;
    else                   next_addr = nxt;
  endfunction

  // ---------------- write FIFO ----------------
  logic [15:0]        wr_mem [DEPTH];
  logic [FIFO_AW-1:0] wf_wptr_r, wf_rptr_r;
  logic               wf_full_s, wf_empty_s, wf_push_s, wf_pop_s;

  assign wf_full_s     = (wr_fifo_num == CNT_FULL);
  assign wf_empty_s    = (wr_fifo_num == CNT_ZERO);
  assign wf_push_s     = wr_fifo_wr_en & ~wf_full_s;
  assign wf_pop_s      = sdram_wr_ack & ~wf_empty_s;
  assign sdram_data_in = wr_mem[wf_rptr_r];

  // Write FIFO storage; no reset on the data array.
  always_ff @(posedge sys_clk) begin
    if (wf_push_s) wr_mem[wf_wptr_r] <= wr_fifo_wr_data;
  end

  // Write FIFO pointers and occupancy.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wf_wptr_r   <= {FIFO_AW{1'b0}};
      wf_rptr_r   <= {FIFO_AW{1'b0}};
      wr_fifo_num <= CNT_ZERO;
    end else begin
      if (wf_push_s) wf_wptr_r <= wf_wptr_r + PTR_ONE;
      if (wf_pop_s)  wf_rptr_r <= wf_rptr_r + PTR_ONE;
      case ({wf_push_s, wf_pop_s})
        2'b10:   wr_fifo_num <= wr_fifo_num + CNT_ONE;
        2'b01:   wr_fifo_num <= wr_fifo_num - CNT_ONE;
        default: wr_fifo_num <= wr_fifo_num;
      endcase
    end
  end

  // ---------------- read FIFO ----------------
  logic [15:0]        rd_mem [DEPTH];
  logic [FIFO_AW-1:0] rf_wptr_r, rf_rptr_r;
  logic               rf_full_s, rf_empty_s, rf_push_s, rf_pop_s;

  assign rf_full_s       = (rd_fifo_num == CNT_FULL);
  assign rf_empty_s      = (rd_fifo_num == CNT_ZERO);
  assign rf_push_s       = sdram_rd_ack & ~rf_full_s;
  assign rf_pop_s        = rd_fifo_rd_en & ~rf_empty_s;
  assign rd_fifo_rd_data = rd_mem[rf_rptr_r];

  // Read FIFO storage; no reset on the data array.
  always_ff @(posedge sys_clk) begin
    if (rf_push_s) rd_mem[rf_wptr_r] <= sdram_data_out;
  end

  // Read FIFO pointers and occupancy.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rf_wptr_r   <= {FIFO_AW{1'b0}};
      rf_rptr_r   <= {FIFO_AW{1'b0}};
      rd_fifo_num <= CNT_ZERO;
    end else begin
      if (rf_push_s) rf_wptr_r <= rf_wptr_r + PTR_ONE;
      if (rf_pop_s)  rf_rptr_r <= rf_rptr_r + PTR_ONE;
      case ({rf_push_s, rf_pop_s})
        2'b10:   rd_fifo_num <= rd_fifo_num + CNT_ONE;
        2'b01:   rd_fifo_num <= rd_fifo_num - CNT_ONE;
        default: rd_fifo_num <= rd_fifo_num;
      endcase
    end
  end

`ifdef SDRAM_FIFO_CTRL_ERR_EN
  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (wr_fifo_wr_en && wf_full_s)  wr_overflow  <= 1'b1;
      if (rd_fifo_rd_en && rf_empty_s) rd_underflow <= 1'b1;
    end
  end
`endif

  // ---------------- request FSM ----------------
  state_t        state_r;
  logic          wr_go_s, rd_go_s;
  logic [CW-1:0] wr_num_w_s, wr_len_w_s, rd_space_w_s, rd_len_w_s;

  assign wr_num_w_s   = {{(CW-FIFO_AW-1){1'b0}}, wr_fifo_num};
  assign wr_len_w_s   = {{(CW-9){1'b0}}, wr_burst_len};
  assign rd_space_w_s = DEPTH_W - {{(CW-FIFO_AW-1){1'b0}}, rd_fifo_num};
  assign rd_len_w_s   = {{(CW-9){1'b0}}, rd_burst_len};
  assign wr_go_s = init_end && (wr_burst_len != 9'd0) && (wr_num_w_s >= wr_len_w_s);
  assign rd_go_s = init_end && read_valid && (rd_burst_len != 9'd0) &&
                   (rd_space_w_s >= rd_len_w_s);

  // Arbitration, request handshakes, address stepping and length capture.
  // Lengths are only sampled while idling so a burst sees stable values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= IDLE;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= WR_BASE;
      sdram_rd_addr <= RD_BASE;
      wr_burst_len  <= 9'd0;
      rd_burst_len  <= 9'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_go_s) begin
            state_r      <= WR_REQ;
            sdram_wr_req <= 1'b1;
          end else if (rd_go_s) begin
            state_r      <= RD_REQ;
            sdram_rd_req <= 1'b1;
          end else begin
            wr_burst_len <= wr_burst_len_in;
            rd_burst_len <= rd_burst_len_in;
          end
        end
        WR_REQ: begin
          if (sdram_wr_ack) begin
            state_r      <= WR_XFER;
            sdram_wr_req <= 1'b0;
          end
        end
        WR_XFER: begin
          if (!sdram_wr_ack) begin
            state_r       <= IDLE;
            sdram_wr_addr <= next_addr(sdram_wr_addr, wr_burst_len, WR_BASE, WR_END);
          end
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            state_r      <= RD_XFER;
            sdram_rd_req <= 1'b0;
          end
        end
        RD_XFER: begin
          if (!sdram_rd_ack) begin
            state_r       <= IDLE;
            sdram_rd_addr <= next_addr(sdram_rd_addr, rd_burst_len, RD_BASE, RD_END);
          end
        end
        default: begin
          state_r      <= IDLE;
          sdram_wr_req <= 1'b0;
          sdram_rd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Directed bench for sdram_fifo_ctrl with write/read scoreboards.
// The write region is shrunk to 24 words so address wrap is reached quickly.
module tb_sdram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        read_valid;
  logic [8:0]  wr_len_in, rd_len_in;
  logic [10:0] wr_num, rd_num;
  logic        init_end;
  logic        wr_req, wr_ack, rd_req, rd_ack;
  logic [23:0] wr_addr, rd_addr;
  logic [8:0]  wr_len, rd_len;
  logic [15:0] data_in, data_out;
`ifdef SDRAM_FIFO_CTRL_ERR_EN
  logic        wr_overflow, rd_underflow;
`endif

  logic [15:0] wr_q[$];
  logic [15:0] rd_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_fifo_ctrl #(.FIFO_AW(10), .WR_BASE(24'd0), .WR_END(24'd24),
                    .RD_BASE(24'd0), .RD_END(24'd1024)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .wr_fifo_wr_en(wr_en), .wr_fifo_wr_data(wr_data),
    .rd_fifo_rd_en(rd_en), .rd_fifo_rd_data(rd_data),
    .read_valid(read_valid),
    .wr_burst_len_in(wr_len_in), .rd_burst_len_in(rd_len_in),
    .wr_fifo_num(wr_num), .rd_fifo_num(rd_num),
`ifdef SDRAM_FIFO_CTRL_ERR_EN
    .wr_overflow(wr_overflow), .rd_underflow(rd_underflow),
`endif
    .init_end(init_end),
    .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack), .sdram_wr_addr(wr_addr),
    .wr_burst_len(wr_len), .sdram_data_in(data_in),
    .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack), .sdram_rd_addr(rd_addr),
    .rd_burst_len(rd_len), .sdram_data_out(data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    wr_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_wr_req(input string tag);
    int n = 0;
    while (!wr_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(wr_req), 32'd1);
  endtask

  task automatic wait_rd_req(input string tag);
    int n = 0;
    while (!rd_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rd_req), 32'd1);
  endtask

  // Ack n words of a write burst, comparing each head word against the queue.
  task automatic wr_burst(input logic [23:0] exp_addr, input int n);
    check("wr_addr", 32'(wr_addr), 32'(exp_addr));
    for (int i = 0; i < n; i++) begin
      wr_ack = 1'b1;
      check("wr_req_hs", 32'(wr_req), (i == 0) ? 32'd1 : 32'd0);
      check("wr_data", 32'(data_in), 32'(wr_q.pop_front()));
      @(negedge clk);
    end
    wr_ack = 1'b0;
    @(negedge clk);
  endtask

  // Return n words base+i on a read burst; optionally drop read_valid mid-burst.
  task automatic rd_burst(input logic [23:0] exp_addr, input int n,
                          input logic [15:0] base, input bit drop_valid);
    check("rd_addr", 32'(rd_addr), 32'(exp_addr));
    for (int i = 0; i < n; i++) begin
      rd_ack = 1'b1;
      data_out = base + 16'(i);
      rd_q.push_back(data_out);
      if (drop_valid && i == 1) read_valid = 1'b0;
      check("rd_req_hs", 32'(rd_req), (i == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_words(input int n);
    for (int i = 0; i < n; i++) begin
      check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      rd_en = 1'b1;
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; rd_en = 1'b0;
    read_valid = 1'b0; wr_len_in = 9'd0; rd_len_in = 9'd0; init_end = 1'b0;
    wr_ack = 1'b0; rd_ack = 1'b0; data_out = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wr_len", 32'(wr_len), 32'd0);
    check("rst_rd_len", 32'(rd_len), 32'd0);
    check("rst_wr_num", 32'(wr_num), 32'd0);
    check("rst_rd_num", 32'(rd_num), 32'd0);
    rst_n = 1'b1;

    // Gating, then basic write once init_end rises
    wr_len_in = 9'd8;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    for (int i = 0; i < 4; i++) begin
      check("gate_no_req", 32'(wr_req), 32'd0);
      @(negedge clk);
    end
    check("gate_num", 32'(wr_num), 32'd8);
    check("wr_len_cap", 32'(wr_len), 32'd8);
    init_end = 1'b1;
    @(negedge clk);
    check("gate_req", 32'(wr_req), 32'd1);
    wr_burst(24'd0, 8);
    check("basic_num", 32'(wr_num), 32'd0);
    check("basic_addr", 32'(wr_addr), 32'd8);

    // Write wrap in a 24-word region: 8, 16, then back to 0
    for (int i = 0; i < 8; i++) push_word(16'h0011 + 16'(i));
    check("lat_pre", 32'(wr_req), 32'd0);
    @(negedge clk);
    check("lat_req", 32'(wr_req), 32'd1);
    wr_burst(24'd8, 8);
    check("addr16", 32'(wr_addr), 32'd16);
    for (int i = 0; i < 8; i++) push_word(16'h0021 + 16'(i));
    wait_wr_req("wr_req3");
    wr_burst(24'd16, 8);
    check("wrap_addr", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 8; i++) push_word(16'h0031 + 16'(i));
    wait_wr_req("wr_req4");
    wr_burst(24'd0, 8);

    // Read prefetch
    rd_len_in = 9'd16;
    read_valid = 1'b1;
    wait_rd_req("rd_req1");
    rd_burst(24'd0, 16, 16'h0100, 1'b0);
    read_valid = 1'b0;
    check("rd_num16", 32'(rd_num), 32'd16);
    check("rd_addr16", 32'(rd_addr), 32'd16);
    pop_words(16);
    check("rd_num0", 32'(rd_num), 32'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("empty_pop", 32'(rd_num), 32'd0);
`ifdef SDRAM_FIFO_CTRL_ERR_EN
    check("underflow", 32'(rd_underflow), 32'd1);
`endif

    // Read burst survives read_valid falling mid-burst
    read_valid = 1'b1;
    wait_rd_req("rd_req2");
    rd_burst(24'd16, 16, 16'h0200, 1'b1);
    check("rv_drop_num", 32'(rd_num), 32'd16);
    check("rd_addr32", 32'(rd_addr), 32'd32);
    check("rv_drop_idle", 32'(rd_req), 32'd0);
    pop_words(16);

    // Simultaneous: write first, read only after IDLE is re-entered
    init_end = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'h0041 + 16'(i));
    read_valid = 1'b1;
    @(negedge clk);
    check("sim_gate_wr", 32'(wr_req), 32'd0);
    check("sim_gate_rd", 32'(rd_req), 32'd0);
    init_end = 1'b1;
    @(negedge clk);
    check("sim_wr", 32'(wr_req), 32'd1);
    check("sim_rd_wait", 32'(rd_req), 32'd0);
    wr_burst(24'd8, 8);
    check("sim_idle_entry", 32'(rd_req), 32'd0);
    check("sim_wr_addr", 32'(wr_addr), 32'd16);
    @(negedge clk);
    check("sim_rd", 32'(rd_req), 32'd1);
    rd_burst(24'd32, 16, 16'h0300, 1'b0);
    read_valid = 1'b0;
    check("sim_rd_num", 32'(rd_num), 32'd16);

    // Asynchronous reset during the 4th write ack
    for (int i = 0; i < 8; i++) push_word(16'h0051 + 16'(i));
    wait_wr_req("wr_req_rst");
    check("rst_burst_addr", 32'(wr_addr), 32'd16);
    for (int i = 0; i < 3; i++) begin
      wr_ack = 1'b1;
      check("rst_burst_data", 32'(data_in), 32'(wr_q.pop_front()));
      @(negedge clk);
    end
    wr_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_wr_req", 32'(wr_req), 32'd0);
    check("mid_rd_req", 32'(rd_req), 32'd0);
    check("mid_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rd_addr", 32'(rd_addr), 32'd0);
    check("mid_wr_num", 32'(wr_num), 32'd0);
    check("mid_rd_num", 32'(rd_num), 32'd0);
    check("mid_wr_len", 32'(wr_len), 32'd0);
    check("mid_rd_len", 32'(rd_len), 32'd0);
`ifdef SDRAM_FIFO_CTRL_ERR_EN
    check("mid_ovf", 32'(wr_overflow), 32'd0);
    check("mid_unf", 32'(rd_underflow), 32'd0);
`endif
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    wr_ack = 1'b0;
    rst_n = 1'b1;

    // Fill the write FIFO to capacity, then push once more
    init_end = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      wr_en = 1'b1;
      wr_data = 16'h1000 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("full_num", 32'(wr_num), 32'd1024);
    check("full_head", 32'(data_in), 32'h1000);
`ifdef SDRAM_FIFO_CTRL_ERR_EN
    check("no_ovf_yet", 32'(wr_overflow), 32'd0);
`endif
    wr_en = 1'b1;
    wr_data = 16'hBEEF;
    @(negedge clk);
    wr_en = 1'b0;
    check("overfull_num", 32'(wr_num), 32'd1024);
    check("overfull_head", 32'(data_in), 32'h1000);
`ifdef SDRAM_FIFO_CTRL_ERR_EN
    check("overflow", 32'(wr_overflow), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_fifo_ctrl.md
# sdram_fifo_ctrl

Single-clock buffering front end placed directly upstream of `sdram_ctrl`. It:
- collects user write data in an internal write FIFO;
- issues burst write requests with auto-incrementing, wrapping addresses;
- prefetches SDRAM data into an internal read FIFO via burst read requests;
- presents both FIFOs to the user side.

It drives `sdram_ctrl`'s `sdram_wr_req/addr/wr_burst_len/sdram_data_in` and `sdram_rd_req/addr/rd_burst_len`, and consumes `sdram_wr_ack`, `sdram_rd_ack`, `sdram_data_out` and `init_end`.

## Interface
Parameters:
- `FIFO_AW`, 10: FIFO address width. Each FIFO is 2^FIFO_AW x 16.
- `WR_BASE`, 24'd0: first write word address.
- `WR_END`, 24'd1024: write region limit (exclusive).
- `RD_BASE`, 24'd0: first read word address.
- `RD_END`, 24'd1024: read region limit (exclusive).

Ports:
- `sys_clk`  in  1: system clock.
- `sys_rst_n`  in  1: reset. **One clock; reset is asynchronous and active-low.**
- `wr_fifo_wr_en`  in  1: push `wr_fifo_wr_data` into the write FIFO.
- `wr_fifo_wr_data`  in  16: user write word.
- `rd_fifo_rd_en`  in  1: pop the read FIFO head.
- `rd_fifo_rd_data`  out  16: read FIFO head, show-ahead.
- `read_valid`  in  1: enables read prefetch.
- `wr_burst_len_in`  in  9: write burst length.
- `rd_burst_len_in`  in  9: read burst length.
- `wr_fifo_num`  out  FIFO_AW+1: write FIFO occupancy.
- `rd_fifo_num`  out  FIFO_AW+1: read FIFO occupancy.
- `init_end`  in  1: SDRAM initialised.
- `sdram_wr_req`  out  1: burst write request.
- `sdram_wr_ack`  in  1: one data word consumed this cycle.
- `sdram_wr_addr`  out  24: burst write start address.
- `wr_burst_len`  out  9: registered copy of `wr_burst_len_in`.
- `sdram_data_in`  out  16: write FIFO head, show-ahead.
- `sdram_rd_req`  out  1: burst read request.
- `sdram_rd_ack`  in  1: `sdram_data_out` valid this cycle.
- `sdram_rd_addr`  out  24: burst read start address.
- `rd_burst_len`  out  9: registered copy of `rd_burst_len_in`.
- `sdram_data_out`  in  16: word read from SDRAM.

## Operation
**FIFOs**
- Both FIFOs are circular buffers with a FIFO_AW-bit pointer and a FIFO_AW+1-bit count.
- Push and pop in the same cycle leaves the count unchanged.
- A push when the FIFO is full is dropped.
- A pop when the FIFO is empty is ignored.
- `sdram_data_in` always shows the write FIFO head; each `sdram_wr_ack` cycle pops one word.
- Each `sdram_rd_ack` cycle pushes `sdram_data_out` into the read FIFO.

**FSM states:** IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER.
- IDLE → WR_REQ when `init_end`=1, `wr_burst_len`≠0 and `wr_fifo_num` ≥ `wr_burst_len`. Write takes priority over read.
- Else IDLE → RD_REQ when `init_end`=1, `read_valid`=1, `rd_burst_len`≠0 and (2^FIFO_AW − `rd_fifo_num`) ≥ `rd_burst_len`.
- WR_REQ: `sdram_wr_req`=1 until the first `sdram_wr_ack` cycle; then → WR_XFER with `sdram_wr_req` low from the next cycle.
- WR_XFER: on the first cycle with `sdram_wr_ack`=0 → IDLE, and the write address is updated.
- RD_REQ and RD_XFER mirror the write states, using `sdram_rd_req` and `sdram_rd_ack`.

**Address update:** `next = addr + len` in 24-bit arithmetic. If `next + len > END` (computed in 25 bits), `next = BASE`.

**Burst length capture:** `wr_burst_len` and `rd_burst_len` are captured from the `_in` ports in IDLE only. They are held constant while a request or transfer is in progress.

## Timing
- Reset values:
  - `sdram_wr_req` = `sdram_rd_req` = 0.
  - `sdram_wr_addr` = WR_BASE; `sdram_rd_addr` = RD_BASE.
  - `wr_burst_len` = `rd_burst_len` = 0.
  - Both counts = 0.
  - `sdram_data_in` and `rd_fifo_rd_data` show memory contents, undefined until the first push (X allowed).
- Request latency: a request is asserted one cycle after the IDLE condition is first seen true. It drops one cycle after the first ack cycle.
- A pushed word is visible at the FIFO head and in the count on the next cycle.
- Ack pop/push takes effect at the clock edge that samples the ack.
- A new request never starts in the cycle that IDLE is re-entered. The earliest start is the following cycle.
- When `read_valid` falls mid-burst, the read burst completes.
- `init_end` falling mid-burst does not abort the burst. No new request is issued while `init_end`=0.
- Asynchronous reset mid-burst returns the FSM to IDLE, clears both FIFOs, and restores base addresses immediately.

## Configuration
- Macro: `SDRAM_FIFO_CTRL_ERR_EN`.
- When defined, adds outputs `wr_overflow` (out 1) and `rd_underflow` (out 1):
  - `wr_overflow` is a sticky flag, set on a push into a full write FIFO.
  - `rd_underflow` is a sticky flag, set on `rd_fifo_rd_en` while the read FIFO is empty.
  - Both are cleared only by reset; reset value 0.
- When not defined, these ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- **Basic write:** `wr_burst_len_in`=8, `init_end`=1, push 8 words 0x0001..0x0008. Required:
  - `sdram_wr_req` rises 1 cycle after the 8th word is visible, with `sdram_wr_addr`=0.
  - Model acks 8 cycles; `sdram_data_in` shows 0x0001..0x0008 in order.
  - `wr_fifo_num` ends at 0; `sdram_wr_addr` becomes 8.
- **Write wrap:** WR_END=24, burst 8, three bursts. Required: addresses 0, 8, 16, then the next request uses 0.
- **Read prefetch:** `read_valid`=1, burst 16, model returns 0x0100+i. Required:
  - `sdram_rd_req` issued at address 0; `rd_fifo_num`=16 after the acks.
  - Popping yields 0x0100..0x010F; the second request is at address 16.
- **Simultaneous requests:** write FIFO at 8 with burst 8, `read_valid`=1, read FIFO empty. Required: write served first; read request raised only after returning to IDLE.
- **Gating:** `init_end`=0 with 8 words queued. Required: no request. Raise `init_end` → `sdram_wr_req` one cycle later.
- **Reset mid-burst and error flags:**
  - Reset during the 4th write ack: all outputs return to reset values; FIFO counts are 0.
  - With `SDRAM_FIFO_CTRL_ERR_EN`: the 1025th push without drain sets `wr_overflow`=1, and a pop of an empty read FIFO sets `rd_underflow`=1.
